// File: rtl/key_event_queue_pkg.sv
// Shared definitions for the keypad input path: key-code width, the "no key"
// code and the accept FSM state type reused by input-filter blocks.
package key_event_queue_pkg;

  localparam int unsigned KEY_W = 5;
  localparam logic [KEY_W-1:0] NO_KEY = 5'h1F;

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    HELD      = 2'd1,
    RELEASING = 2'd2
  } accept_state_t;

endpackage

// File: rtl/key_fifo.sv
// Generic synchronous FIFO with registered storage; full/empty are derived
// from the occupancy count, and pointers wrap naturally (DEPTH is a power of two).
module key_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign rd_data = mem[rd_ptr];
  assign count   = cnt;

endmodule

// File: rtl/key_event_queue.sv
// Turns the scanner's press level into one event per physical press (with a
// release-time re-arm filter) and queues the events behind a valid/ready port.
module key_event_queue
  import key_event_queue_pkg::*;
#(
  parameter int unsigned      DEPTH          = 4,
  parameter int unsigned      RELEASE_CYCLES = 50000,
  parameter logic [KEY_W-1:0] NO_KEY         = key_event_queue_pkg::NO_KEY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KEY_W-1:0]       key_in,
  input  logic                   pressed_in,
  output logic                   evt_valid,
  output logic [KEY_W-1:0]       evt_key,
  input  logic                   evt_ready,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam int unsigned CNT_W = $clog2(RELEASE_CYCLES + 1);

  accept_state_t    state_q;
  accept_state_t    state_d;
  logic [CNT_W-1:0] rel_cnt_q;
  logic [CNT_W-1:0] rel_cnt_d;
  logic             push_req;
  logic             pop_req;
  logic             fifo_full;
  logic             fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARMED;
      rel_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rel_cnt_q <= rel_cnt_d;
    end
  end

  // The counter holds the number of consecutive low cycles seen so far,
  // including the one that left HELD.
  always_comb begin
    state_d   = state_q;
    rel_cnt_d = rel_cnt_q;
    push_req  = 1'b0;
    unique case (state_q)
      ARMED: begin
        if (pressed_in) begin
          state_d  = HELD;
          push_req = (key_in != NO_KEY);
        end
      end
      HELD: begin
        if (!pressed_in) begin
          rel_cnt_d = CNT_W'(1);
          state_d   = (RELEASE_CYCLES <= 1) ? ARMED : RELEASING;
        end
      end
      RELEASING: begin
        if (pressed_in) begin
          state_d = HELD;
        end else begin
          rel_cnt_d = rel_cnt_q + 1'b1;
          if (rel_cnt_q == CNT_W'(RELEASE_CYCLES - 1)) begin
            state_d = ARMED;
          end
        end
      end
      default: state_d = ARMED;
    endcase
  end

  assign evt_valid = !fifo_empty;
  assign pop_req   = evt_valid && evt_ready;

  key_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_req),
    .pop     (pop_req),
    .wr_data (key_in),
    .rd_data (evt_key),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (evt_count)
  );

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !pop_req) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue: directed scenarios plus a randomized
// run compared each cycle against a queue-based reference model.
module tb_key_event_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned RC    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] key_in = '0;
  logic       pressed_in = 1'b0;
  logic       evt_valid;
  logic [4:0] evt_key;
  logic       evt_ready = 1'b0;
  logic [2:0] evt_count;
  logic       overflow;
  logic       clr_ovf = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a press is accepted when at least RC low cycles have
  // elapsed since the last high cycle (or none since reset).
  logic [4:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  int         low_run = RC;

  always #5 clk = ~clk;

  key_event_queue #(
    .DEPTH          (DEPTH),
    .RELEASE_CYCLES (RC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .pressed_in (pressed_in),
    .evt_valid  (evt_valid),
    .evt_key    (evt_key),
    .evt_ready  (evt_ready),
    .evt_count  (evt_count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  task automatic model_reset();
    exp_q.delete();
    exp_ovf = 1'b0;
    low_run = RC;
  endtask

  task automatic model_step();
    bit pop, push, drop;
    pop  = (exp_q.size() != 0) && evt_ready;
    push = pressed_in && (low_run >= RC) && (key_in != 5'h1F);
    if (pressed_in) low_run = 0;
    else if (low_run < RC) low_run++;
    drop = push && (exp_q.size() == DEPTH) && !pop;
    if (pop) void'(exp_q.pop_front());
    if (push && !drop) exp_q.push_back(key_in);
    if (drop) exp_ovf = 1'b1;
    else if (clr_ovf) exp_ovf = 1'b0;
  endtask

  task automatic tick();
    if (!rst_n) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] k, input int hi, input int lo);
    key_in = k;
    pressed_in = 1'b1;
    repeat (hi) tick();
    pressed_in = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (evt_valid !== 1'b0 || evt_count !== 3'd0 || overflow !== 1'b0 || evt_key !== 5'd0)
      $display("FAIL reset_outputs got v=%b c=%0d o=%b k=%0d want 0/0/0/0", evt_valid, evt_count, overflow, evt_key);
    else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (evt_valid !== 1'b0 || evt_count !== 3'd0)
      $display("FAIL reset_idle got v=%b c=%0d want 0/0", evt_valid, evt_count);
    else n_pass++;
  endtask

  task automatic test_single_press();
    key_in = 5'd7;
    pressed_in = 1'b1;
    tick();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_key !== 5'd7 || evt_count !== 3'd1)
      $display("FAIL single_latency got v=%b k=%0d c=%0d want 1/7/1", evt_valid, evt_key, evt_count);
    else n_pass++;
    repeat (19) tick();
    n_checks++;
    if (evt_count !== 3'd1 || evt_key !== 5'd7)
      $display("FAIL single_held got c=%0d k=%0d want 1/7", evt_count, evt_key);
    else n_pass++;
    pressed_in = 1'b0;
    repeat (RC) tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_checks++;
    if (evt_valid !== 1'b0 || evt_count !== 3'd0)
      $display("FAIL single_drain got v=%b c=%0d want 0/0", evt_valid, evt_count);
    else n_pass++;
  endtask

  task automatic test_bounce();
    press(5'd3, 2, 5);
    press(5'd3, 4, RC);
    press(5'd4, 2, RC);
    n_checks++;
    if (evt_count !== 3'd2 || evt_key !== 5'd3)
      $display("FAIL bounce_count got c=%0d k=%0d want 2/3", evt_count, evt_key);
    else n_pass++;
    evt_ready = 1'b1;
    tick();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_key !== 5'd4)
      $display("FAIL bounce_second got v=%b k=%0d want 1/4", evt_valid, evt_key);
    else n_pass++;
    tick();
    evt_ready = 1'b0;
    n_checks++;
    if (evt_valid !== 1'b0)
      $display("FAIL bounce_empty got v=%b want 0", evt_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) press(5'(i), 1, RC);
    n_checks++;
    if (evt_count !== 3'd4 || overflow !== 1'b0 || evt_key !== 5'd1)
      $display("FAIL ovf_full got c=%0d o=%b k=%0d want 4/0/1", evt_count, overflow, evt_key);
    else n_pass++;
    press(5'd5, 1, RC);
    n_checks++;
    if (evt_count !== 3'd4 || overflow !== 1'b1 || evt_key !== 5'd1)
      $display("FAIL ovf_drop got c=%0d o=%b k=%0d want 4/1/1", evt_count, overflow, evt_key);
    else n_pass++;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b0 || evt_count !== 3'd4)
      $display("FAIL ovf_clear got o=%b c=%0d want 0/4", overflow, evt_count);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    logic [4:0] want [4];
    want[0] = 5'd2; want[1] = 5'd3; want[2] = 5'd4; want[3] = 5'd9;
    key_in = 5'd9;
    pressed_in = 1'b1;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    pressed_in = 1'b0;
    n_checks++;
    if (overflow !== 1'b0 || evt_count !== 3'd4 || evt_key !== 5'd2)
      $display("FAIL fullpop_accept got o=%b c=%0d k=%0d want 0/4/2", overflow, evt_count, evt_key);
    else n_pass++;
    repeat (RC) tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (evt_valid !== 1'b1 || evt_key !== want[i])
        $display("FAIL fullpop_order[%0d] got v=%b k=%0d want 1/%0d", i, evt_valid, evt_key, want[i]);
      else n_pass++;
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    n_checks++;
    if (evt_valid !== 1'b0 || evt_count !== 3'd0)
      $display("FAIL fullpop_empty got v=%b c=%0d want 0/0", evt_valid, evt_count);
    else n_pass++;
  endtask

  task automatic test_no_key();
    press(5'h1F, 2, 1);
    n_checks++;
    if (evt_valid !== 1'b0 || evt_count !== 3'd0)
      $display("FAIL nokey_event got v=%b c=%0d want 0/0", evt_valid, evt_count);
    else n_pass++;
    repeat (RC - 1) tick();
    press(5'd5, 1, 0);
    n_checks++;
    if (evt_count !== 3'd1 || evt_key !== 5'd5)
      $display("FAIL nokey_rearm got c=%0d k=%0d want 1/5", evt_count, evt_key);
    else n_pass++;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    repeat (RC) tick();
  endtask

  task automatic test_async_reset();
    press(5'd10, 1, RC);
    press(5'd11, 1, 2);
    n_checks++;
    if (evt_count !== 3'd2)
      $display("FAIL areset_fill got c=%0d want 2", evt_count);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (evt_valid !== 1'b0 || evt_count !== 3'd0 || overflow !== 1'b0)
      $display("FAIL areset_immediate got v=%b c=%0d o=%b want 0/0/0", evt_valid, evt_count, overflow);
    else n_pass++;
    model_reset();
    #2;
    rst_n = 1'b1;
    key_in = 5'd12;
    pressed_in = 1'b1;
    tick();
    pressed_in = 1'b0;
    n_checks++;
    if (evt_valid !== 1'b1 || evt_key !== 5'd12 || evt_count !== 3'd1)
      $display("FAIL areset_armed got v=%b k=%0d c=%0d want 1/12/1", evt_valid, evt_key, evt_count);
    else n_pass++;
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    repeat (RC) tick();
  endtask

  task automatic test_random();
    int run_left = 0;
    int errs = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (run_left == 0) begin
        pressed_in = ~pressed_in;
        run_left = $urandom_range(1, 12);
        if (pressed_in) key_in = ($urandom_range(0, 9) == 0) ? 5'h1F : 5'($urandom_range(0, 31));
      end
      run_left--;
      evt_ready = ($urandom_range(0, 3) == 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      tick();
      n_checks++;
      if (evt_count !== 3'(exp_q.size()) || evt_valid !== (exp_q.size() != 0)) begin
        if (errs < 10) $display("FAIL rand_count cyc %0d got c=%0d v=%b want c=%0d", cyc, evt_count, evt_valid, exp_q.size());
        errs++;
      end else n_pass++;
      n_checks++;
      if (overflow !== exp_ovf) begin
        if (errs < 10) $display("FAIL rand_ovf cyc %0d got %b want %b", cyc, overflow, exp_ovf);
        errs++;
      end else n_pass++;
      if (exp_q.size() != 0) begin
        n_checks++;
        if (evt_key !== exp_q[0]) begin
          if (errs < 10) $display("FAIL rand_key cyc %0d got %0d want %0d", cyc, evt_key, exp_q[0]);
          errs++;
        end else n_pass++;
      end
    end
    evt_ready = 1'b0;
    clr_ovf = 1'b0;
    pressed_in = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_overflow();
    test_full_pop();
    test_no_key();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
